// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for serial_adder_ctrl: an operand request channel
// (in_valid/in_ready carrying A, B, cin) and a result channel
// (out_valid/out_ready carrying sum, carry, ovf), plus a busy status flag.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             busy;

    // Requester / result consumer side
    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, sum, carry, ovf, busy
    );

    // Adder side
    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, sum, carry, ovf, busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder. Operands are captured in parallel on a
// valid/ready handshake, then one bit pair per clock (LSB first) is passed
// through a full adder built from two half adders. The parallel sum, the
// unsigned carry-out and the signed overflow are presented on a second
// valid/ready handshake. Every output is driven straight from a flop.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Half adder: returns {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    // Holds the WIDTH-1 sum bits already produced; the final bit joins on the last edge
    logic [WIDTH-2:0] s_sr_q, s_sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [1:0]       ha1_s;
    logic [1:0]       ha2_s;
    logic             cout_s;
    logic [WIDTH-1:0] s_cat_s;

    // State, datapath and output registers; async reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sr_q      <= {WIDTH{1'b0}};
            b_sr_q      <= {WIDTH{1'b0}};
            s_sr_q      <= {(WIDTH-1){1'b0}};
            c_q         <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            s_sr_q      <= s_sr_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, serial full-adder step and next output values
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        // Full adder from two half adders on the current LSBs and carry
        ha1_s   = half_add(a_sr_q[0], b_sr_q[0]);
        ha2_s   = half_add(ha1_s[0], c_q);
        cout_s  = ha1_s[1] | ha2_s[1];
        s_cat_s = {ha2_s[0], s_sr_q};

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sr_d  = bus.A;
                    b_sr_d  = bus.B;
                    s_sr_d  = {(WIDTH-1){1'b0}};
                    c_d     = bus.cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                c_d    = cout_s;
                a_sr_d = a_sr_q >> 1'b1;
                b_sr_d = b_sr_q >> 1'b1;
                s_sr_d = s_cat_s[WIDTH-1:1];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // c_q is the carry into the MSB, cout_s the carry out of it
                    sum_d   = s_cat_s;
                    carry_d = cout_s;
                    ovf_d   = c_q ^ cout_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_SHIFT) || (state_d == ST_DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results come
// from an arithmetic reference model, are queued when operands are accepted
// and are compared when the adder presents a result.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;
    res_t exp_q[$];

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] full;
        res_t r;
        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        r.sum   = full[W-1:0];
        r.carry = full[W];
        r.ovf   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.sum   = bus.sum;
        r.carry = bus.carry;
        r.ovf   = bus.ovf;
        return r;
    endfunction

    // Drive one operand set for a single edge (caller is #1 after an edge in IDLE)
    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        bus.A        = a;
        bus.B        = b;
        bus.cin      = ci;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(a, b, ci));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat = cycles since accept, -1 on timeout
    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
        checks++;
        if ({bus.sum, bus.carry, bus.ovf} !== 10'd0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 000", {bus.sum, bus.carry, bus.ovf});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL post_release_idle: got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
    endtask

    task automatic test_arith();
        vec_t tbl[5];
        res_t e;
        int   lat;
        tbl[0] = {8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = {8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = {8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = {8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         ci;
            if (i < 5) begin
                a  = tbl[i].a;
                b  = tbl[i].b;
                ci = tbl[i].ci;
            end else begin
                a  = W'($urandom);
                b  = W'($urandom);
                ci = 1'($urandom);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL arith_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            accept_op(a, b, ci);
            checks++;
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL arith_busy[%0d]: got busy=%b in_ready=%b expected 1/0", i, bus.busy, bus.in_ready);
            end
            wait_out(lat);
            checks++;
            if (lat !== W) begin
                errors++;
                $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, W);
            end
            if (lat > 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dut_res() !== e) begin
                    errors++;
                    $display("FAIL arith_result[%0d]: got sum=%h c=%b v=%b expected sum=%h c=%b v=%b",
                             i, bus.sum, bus.carry, bus.ovf, e.sum, e.carry, e.ovf);
                end
                if (i < 5) begin
                    checks++;
                    if ({bus.sum, bus.carry, bus.ovf} !== {tbl[i].s, tbl[i].co, tbl[i].ov}) begin
                        errors++;
                        $display("FAIL arith_vector[%0d]: got sum=%h c=%b v=%b expected sum=%h c=%b v=%b",
                                 i, bus.sum, bus.carry, bus.ovf, tbl[i].s, tbl[i].co, tbl[i].ov);
                    end
                end
            end else begin
                exp_q.delete();
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
                errors++;
                $display("FAIL arith_return_idle[%0d]: got %b expected 100", i, {bus.in_ready, bus.out_valid, bus.busy});
            end
        end
    endtask

    task automatic test_backpressure();
        res_t e;
        int   lat;
        bus.out_ready = 1'b0;
        accept_op(8'h33, 8'h44, 1'b1);
        // Keep offering a different operand through SHIFT and DONE
        bus.A        = 8'h11;
        bus.B        = 8'h11;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        wait_out(lat);
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL bp_latency: got %0d expected %0d", lat, W);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : res_t'(0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, dut_res()} !== {1'b1, 1'b0, e}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%b sum=%h c=%b o=%b expected v=1 r=0 sum=%h c=%b o=%b",
                         k, bus.out_valid, bus.in_ready, bus.sum, bus.carry, bus.ovf, e.sum, e.carry, e.ovf);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL bp_release: got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
        checks++;
        if (dut_res() !== e) begin
            errors++;
            $display("FAIL bp_result_kept: got sum=%h expected sum=%h", bus.sum, e.sum);
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        int   n_acc;
        int   n_res;
        int   t0;
        int   t1;
        int   k;
        logic rdy;
        n_acc = 0;
        n_res = 0;
        t0    = 0;
        t1    = 0;
        k     = 0;
        bus.out_ready = 1'b1;
        bus.A         = 8'h01;
        bus.B         = 8'h02;
        bus.cin       = 1'b0;
        bus.in_valid  = 1'b1;
        while (n_res < 2 && k < 40) begin
            k++;
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy && bus.in_valid) begin
                n_acc++;
                exp_q.push_back(model(bus.A, bus.B, bus.cin));
                if (n_acc == 1) begin
                    t0    = cyc;
                    bus.A = 8'h10;
                    bus.B = 8'h20;
                end else begin
                    t1           = cyc;
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                n_res++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got result %h expected none", bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (dut_res() !== e) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got sum=%h c=%b expected sum=%h c=%b",
                                 n_res, bus.sum, bus.carry, e.sum, e.carry);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (n_res !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", n_res);
        end
        checks++;
        if (t1 - t0 !== W + 2) begin
            errors++;
            $display("FAIL b2b_interval: got %0d expected %0d", t1 - t0, W + 2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        res_t e;
        int   lat;
        bus.out_ready = 1'b1;
        bus.A        = 8'hAA;
        bus.B        = 8'h55;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.carry, bus.ovf} !== {3'b100, 10'd0}) begin
            errors++;
            $display("FAIL midreset_outputs: got r=%b v=%b b=%b sum=%h c=%b o=%b expected 1 0 0 00 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.carry, bus.ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_result: got %b expected 0", bus.out_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        accept_op(8'h0F, 8'h01, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL midreset_latency: got %0d expected %0d", lat, W);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : res_t'(0);
        checks++;
        if ({bus.sum, bus.carry, bus.ovf} !== {8'h10, 1'b0, 1'b0} || dut_res() !== e) begin
            errors++;
            $display("FAIL midreset_result: got sum=%h c=%b o=%b expected sum=10 c=0 o=0",
                     bus.sum, bus.carry, bus.ovf);
        end
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        cyc           = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder that accepts two parallel operands and a carry-in over a valid/ready handshake. It streams one bit pair per clock, LSB first, through an internal two-half-adder full-adder stage, and returns the parallel sum, carry-out and signed overflow over a second handshake. It sits directly upstream of the half-adder datapath: it sequences the operand bits into the half adders and collects what they produce. Area is traded for latency.

## Interface
- WIDTH, 8: operand/sum width in bits; legal range 2..32.

- clk  input  1  system clock, rising-edge active; one clock; reset is asynchronous and active-low
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands A, B, cin valid this cycle
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  operand A, sampled on accept
- B  input  WIDTH  operand B, sampled on accept
- cin  input  1  carry-in, sampled on accept
- out_valid  output  1  sum/carry/ovf hold a completed result
- out_ready  input  1  consumer takes the result
- sum  output  WIDTH  registered sum A+B+cin, modulo 2^WIDTH
- carry  output  1  registered unsigned carry-out
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB
- busy  output  1  high in SHIFT or DONE

## Operation
- States are IDLE, SHIFT and DONE. Reset places the block in IDLE.
- IDLE: in_ready=1.
  - Accept occurs on a clock edge with in_valid=1.
  - On accept: load shift registers a_sr=A and b_sr=B; set carry register c=cin; set bit counter cnt=0; go to SHIFT.
- SHIFT: in_ready=0. On each edge:
  - Half adder 1: p=a_sr[0]^b_sr[0], g1=a_sr[0]&b_sr[0].
  - Half adder 2: s=p^c, g2=p&c.
  - Next carry: c<=g1|g2.
  - Shift s into the MSB of s_sr, shifting s_sr right. Shift a_sr and b_sr right. Increment cnt.
  - On the edge where cnt==WIDTH-1 (the last bit):
    - capture cmsb=c (the carry into the MSB);
    - load sum<=final s_sr, carry<=g1|g2, ovf<=cmsb^(g1|g2);
    - go to DONE.
- DONE: out_valid=1.
  - On an edge with out_ready=1, go to IDLE; out_valid falls.
  - With out_ready=0, hold indefinitely.
- Output registers: sum, carry and ovf change only on entry to DONE. They keep the last result through IDLE and SHIFT until the next DONE entry.
- Protocol rules:
  - in_valid while busy is ignored; no operand is captured and no error is flagged.
  - out_ready outside DONE has no effect.
  - The block does not accept new operands in the same cycle out_ready is accepted; IDLE must be entered first.
- Arithmetic: unsigned result is {carry,sum} = A+B+cin, exact. Signed interpretation is two's complement, with ovf per the rule above.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry=0, ovf=0, and all internal registers 0.
- Reset release is synchronised by design usage: no accept is expected on the first edge after deassertion.
- Latency: accept at edge E0. SHIFT occupies edges E0+1..E0+WIDTH. out_valid is high from E0+WIDTH, i.e. WIDTH cycles after accept.
- Minimum issue interval is WIDTH+2 cycles: WIDTH shift cycles, 1 DONE cycle (with out_ready=1), and 1 IDLE accept cycle.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Reset asserted mid-SHIFT or in DONE: all outputs return to their reset values immediately. The partial result is discarded and never presented.

## Test plan
- WIDTH=8, accept A=0x5A, B=0x3C, cin=0 -> out_valid exactly 8 cycles after accept; sum=0x96, carry=0, ovf=1.
- A=0xFF, B=0x01, cin=0 -> sum=0x00, carry=1, ovf=0. Separately, A=0xFF, B=0xFF, cin=1 -> sum=0xFF, carry=1, ovf=0.
- A=0x80, B=0x80, cin=0 -> sum=0x00, carry=1, ovf=1. Separately, A=0x7F, B=0x01, cin=0 -> sum=0x80, carry=0, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, carry and ovf remain stable.
  - Pulse in_valid with A=0x11 during SHIFT and DONE -> ignored; the result is unchanged.
  - Raise out_ready -> IDLE on the next edge, in_ready=1.
- Back-to-back: 0x01+0x02 followed immediately by 0x10+0x20, with out_ready tied 1 -> results 0x03 then 0x30; accept edges are exactly 10 cycles apart.
- Accept A=0xAA, B=0x55, then drop rst_n at shift cycle 4 -> all outputs take reset values immediately. After release, accept 0x0F+0x01 -> sum=0x10, carry=0, with no residue from the aborted operation.
